// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch port and a load/store port. Data wins by default. A starvation
// counter hands the slot to fetch after STARVE_MAX back-to-back data grants
// made while fetch was waiting. Each access is one issue cycle, then
// MEM_LATENCY counted edges, then a one-cycle done pulse back in IDLE.

module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,

    output logic        stall_if,
    output logic        stall_mem
);

    localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [WCW-1:0] wait_cnt;
    logic [SCW-1:0] starve_cnt;
    logic           lat_we;     // in-flight data access is a store
    logic           grant_d;
    logic           grant_if;
    logic           last_edge;  // this edge is the final counted (capture) edge
    logic           starved;

    // Fetch is owed the slot once data has won STARVE_MAX times in a row.
    assign starved   = (starve_cnt == SCW'(STARVE_MAX));
    assign last_edge = (wait_cnt == WCW'(MEM_LATENCY - 1));

    // Arbitration and next-state decode; grants only happen in IDLE, so
    // input changes while busy cannot disturb the in-flight access.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && starved)) begin
                    grant_d    = 1'b1;
                    state_next = D_BUSY;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (last_edge) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Latency counter: counts edges from the issue cycle, restarts per access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state != IDLE) begin
            wait_cnt <= last_edge ? '0 : wait_cnt + WCW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Starvation counter: counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end else if (grant_if || (state == IDLE && !if_req)) begin
            starve_cnt <= '0;
        end
    end

    // Memory issue: latch the winner at grant, strobe for exactly one cycle,
    // hold address/data/enables afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            lat_we    <= 1'b0;
        end else begin
            mem_en <= grant_d | grant_if;
            mem_we <= grant_d & d_we;
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
                lat_we    <= d_we;
            end else if (grant_if) begin
                mem_addr  <= if_addr;
                mem_be    <= 4'hF;
                lat_we    <= 1'b0;
            end
        end
    end

    // Read capture on the final counted edge; done pulses the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_done <= (state == IF_BUSY) && last_edge;
            d_done  <= (state == D_BUSY) && last_edge;
            if (state == IF_BUSY && last_edge) if_rdata <= mem_rdata;
            if (state == D_BUSY && last_edge && !lat_we) d_rdata <= mem_rdata;
        end
    end

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// issues and read data into queues, a negedge monitor pops and compares.
// A second instance with MEM_LATENCY=1 covers back-to-back fetch throughput.

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // main instance (MEM_LATENCY=2)
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_done, d_done, mem_en, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // second instance (MEM_LATENCY=1)
    logic        b_if_req;
    logic [31:0] b_if_addr;
    logic        b_d_req = 1'b0, b_d_we = 1'b0;
    logic [31:0] b_d_addr = '0, b_d_wdata = '0;
    logic [3:0]  b_d_be = '0;
    logic        b_if_done, b_d_done, b_mem_en, b_mem_we, b_stall_if, b_stall_mem;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_be;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_wd;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    logic [31:0] last_d;   // model of d_rdata contents

    // Directed memory contents.
    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_2000: return 32'hCAFE_F00D;
            32'h0000_0400: return 32'h1234_5678;
            32'h0000_3000: return 32'h0BAD_C0DE;
            32'h0000_0500: return 32'h5555_5555;
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0008: return 32'h0020_0113;
            default:       return 32'hFFFF_0000;
        endcase
    endfunction

    assign mem_rdata   = memval(mem_addr);
    assign b_mem_rdata = memval(b_mem_addr);

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(4)) u0 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(4)) u1 (
        .clk(clk), .reset_n(reset_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_be(b_d_be),
        .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_be(b_mem_be), .mem_rdata(b_mem_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents an issue or done.
    logic prev_en = 1'b0;
    int   issue_cyc = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_en) begin
                check("mem_en_one_cycle", {31'b0, prev_en}, 32'h0);
                if (exp_mem.size() == 0) begin
                    fail_now("unexpected_mem_issue");
                end else begin
                    check("mem_we",   {31'b0, mem_we}, {31'b0, exp_mem[0].we});
                    check("mem_addr", mem_addr, exp_mem[0].addr);
                    check("mem_be",   {28'b0, mem_be}, {28'b0, exp_mem[0].be});
                    if (exp_mem[0].chk_wd) check("mem_wdata", mem_wdata, exp_mem[0].wdata);
                    exp_mem.delete(0);
                end
                issue_cyc <= cyc;
            end
            if (if_done || d_done)
                check("done_exclusive", {31'b0, if_done & d_done}, 32'h0);
            if (if_done) begin
                check("if_done_latency", cyc - issue_cyc, 32'd2);
                if (exp_if.size() == 0) fail_now("unexpected_if_done");
                else begin
                    check("if_rdata", if_rdata, exp_if[0]);
                    exp_if.delete(0);
                end
            end
            if (d_done) begin
                check("d_done_latency", cyc - issue_cyc, 32'd2);
                if (exp_d.size() == 0) fail_now("unexpected_d_done");
                else begin
                    check("d_rdata", d_rdata, exp_d[0]);
                    exp_d.delete(0);
                end
            end
        end
        prev_en <= mem_en;
    end

    task automatic exp_fetch(input logic [31:0] a, input logic [31:0] rd);
        exp_mem.push_back('{1'b0, a, 32'h0, 4'hF, 1'b0});
        exp_if.push_back(rd);
    endtask

    task automatic exp_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] rd);
        exp_mem.push_back('{we, a, wd, be, 1'b1});
        if (!we) last_d = rd;
        exp_d.push_back(last_d);
    endtask

    // Wait for the given number of done pulses. Without hold, each port drops
    // its request in its done cycle; with hold, both stay up until the end.
    task automatic service(input int n_if, input int n_d, input bit hold, input bit chk);
        int nif = 0;
        int nd = 0;
        bit prev_dd = 1'b0;
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (chk && prev_dd) begin
                check("fetch_issue_after_d_done", {31'b0, mem_en}, 32'h1);
                check("fetch_addr_after_d_done", mem_addr, if_addr);
            end
            if (chk && nif < n_if) check("stall_if", {31'b0, stall_if}, if_done ? 32'h0 : 32'h1);
            if (chk && nd < n_d)   check("stall_mem", {31'b0, stall_mem}, d_done ? 32'h0 : 32'h1);
            prev_dd = d_done;
            if (if_done) begin nif++; if (!hold) if_req = 1'b0; end
            if (d_done)  begin nd++;  if (!hold) d_req  = 1'b0; end
            if (nif >= n_if && nd >= n_d) begin
                if (hold) begin if_req = 1'b0; d_req = 1'b0; end
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("service_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b_exp [3];
        int k, j, last_done;
        bit seen, b_prev_en;

        reset_n = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        b_if_req = 0; b_if_addr = 0;
        last_d = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        check("rst_mem_en",   {31'b0, mem_en}, 32'h0);
        check("rst_dones",    {30'b0, if_done, d_done}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rdata",    if_rdata | d_rdata, 32'h0);
        check("rst_stalls",   {30'b0, stall_if, stall_mem}, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // single fetch
        exp_fetch(32'h100, 32'h0050_0093);
        if_addr = 32'h100; if_req = 1'b1;
        service(1, 0, 1'b0, 1'b0);

        // simultaneous fetch and load: data first, fetch right after d_done
        exp_data(1'b0, 32'h2000, 32'h0, 4'hF, 32'hCAFE_F00D);
        exp_fetch(32'h400, 32'h1234_5678);
        d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'h0; d_be = 4'hF; d_req = 1'b1;
        if_addr = 32'h400; if_req = 1'b1;
        service(1, 1, 1'b0, 1'b1);

        // store leaves d_rdata alone
        exp_data(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; d_req = 1'b1;
        service(0, 1, 1'b0, 1'b0);
        check("store_keeps_d_rdata", d_rdata, 32'hCAFE_F00D);

        // starvation: both held, expect D,D,D,D,F,D
        for (int i = 0; i < 4; i++) exp_data(1'b0, 32'h3000, 32'h0, 4'b1100, 32'h0BAD_C0DE);
        exp_fetch(32'h400, 32'h1234_5678);
        exp_data(1'b0, 32'h3000, 32'h0, 4'b1100, 32'h0BAD_C0DE);
        d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h0; d_be = 4'b1100; d_req = 1'b1;
        if_addr = 32'h400; if_req = 1'b1;
        service(1, 5, 1'b1, 1'b0);

        // reset in the cycle after mem_en
        exp_mem.push_back('{1'b0, 32'h500, 32'h0, 4'hF, 1'b0});
        if_addr = 32'h500; if_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mem_en) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("reset_test_no_issue");
        @(posedge clk); #1;
        reset_n = 1'b0; if_req = 1'b0;
        #1;
        check("mid_rst_strobes", {28'b0, mem_en, mem_we, if_done, d_done}, 32'h0);
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        check("mid_rst_mem_wdata", mem_wdata, 32'h0);
        check("mid_rst_mem_be", {28'b0, mem_be}, 32'h0);
        check("mid_rst_if_rdata", if_rdata, 32'h0);
        check("mid_rst_d_rdata", d_rdata, 32'h0);
        last_d = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {29'b0, mem_en, if_done, d_done}, 32'h0);
        end

        // MEM_LATENCY=1 back-to-back fetches 0x0, 0x4, 0x8
        b_exp[0] = 32'h0000_0013; b_exp[1] = 32'h0010_0093; b_exp[2] = 32'h0020_0113;
        k = 0; j = 0; last_done = 0; b_prev_en = 1'b0;
        b_if_addr = 32'h0; b_if_req = 1'b1;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(posedge clk); #1;
            if (b_mem_en) begin
                check("b_mem_en_gap", {31'b0, b_prev_en}, 32'h0);
                check("b_mem_addr", b_mem_addr, 32'(j * 4));
                j++;
            end
            b_prev_en = b_mem_en;
            if (b_if_done) begin
                check("b_if_rdata", b_if_rdata, b_exp[k]);
                if (k > 0) check("b_done_spacing", cyc - last_done, 32'd2);
                last_done = cyc;
                k++;
                if (k < 3) b_if_addr = 32'(k * 4);
                else       b_if_req = 1'b0;
            end
        end
        if (k < 3) fail_now("b_fetch_timeout");
        repeat (3) @(posedge clk);
        #1;

        check("exp_mem_drained", exp_mem.size(), 32'h0);
        check("exp_if_drained", exp_if.size(), 32'h0);
        check("exp_d_drained", exp_d.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
